lynx_tape_player: RTL and testbench
===================================

Name: lynx_tape_player

Overview:
- Virtual cassette deck that produces the `ear` tape-input signal read by the Lynx core through the port 80h bit 0 path.
- The host (OSD/ioctl loader) pushes tape-image bytes into an internal FIFO.
- The block emits leader, sync byte and data as square-wave cycles, gated by the cassette motor line.
- Sits directly upstream of the core's `ear` input and the audio tape mix.

Parameters:
- AW, 4: FIFO address width; depth is 2^AW entries of 9 bits (8 data bits plus 1 last flag).
- ZERO_HALF, 1000: half-period of a 0-bit cycle, in ce ticks.
- ONE_HALF, 500: half-period of a 1-bit cycle, in ce ticks.
- LEADER_CYCLES, 768: number of 0-bit cycles in the leader.
- SYNC_BYTE, 8'hA5: byte sent between the leader and the data.
- GAP_TICKS, 40000: trailing silence after the last byte, in ce ticks.

Ports:
- clock  in  1  system clock (the block's one clock).
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  timing tick enable; all tape timing counts ce ticks.
- motor  in  1  cassette motor; when low, playback is frozen.
- start  in  1  single-clock pulse that begins a block (leader).
- stop  in  1  single-clock pulse that aborts playback and flushes the FIFO.
- wr  in  1  FIFO write strobe, one byte per clock.
- di  in  8  byte to write.
- last  in  1  qualifies `wr`: this byte ends the block.
- full  out  1  FIFO full.
- count  out  AW+1  FIFO occupancy.
- busy  out  1  high in every state except IDLE.
- ear  out  1  tape signal to the core.

Behaviour:
- Reset (asynchronous, active-low) drives: state IDLE, ear=0, busy=0, FIFO empty (count=0, full=0), all counters 0, last flag cleared.
- FIFO writes:
  - A write is accepted on any clock (not ce-gated) when wr=1 and full=0, as sampled before any same-cycle pop.
  - A write while full is dropped; count and contents are unchanged.
  - A pop and a write in the same clock leave count unchanged.
  - full = (count == 2^AW).
- Bit cycle: ear=1 for H ticks, then ear=0 for H ticks. H = ONE_HALF for a 1-bit, ZERO_HALF for a 0-bit.
  - Bytes are sent MSB first.
  - A tick is a clock with ce=1 and motor=1.
- State machine:
  - IDLE: ear=0. A start pulse moves to LEADER. start outside IDLE is ignored.
  - LEADER: ear rises on the first tick after entry. Sends LEADER_CYCLES 0-bit cycles, then moves to SYNC.
  - SYNC: sends SYNC_BYTE, then moves to DATA.
  - DATA: at each byte boundary, pops the FIFO head into the shift register in the same clock as the boundary.
    - If the FIFO is empty at the boundary, moves to STALL.
    - When a byte carrying the last flag finishes its final low half, moves to GAP.
  - STALL: ear=0, no tick counting. On the first clock with a non-empty FIFO, pops and returns to DATA. The next tick starts the high half.
  - GAP: ear=0 for GAP_TICKS ticks, then moves to IDLE. busy falls on entry to IDLE.
- Motor low:
  - The state, the half-period counter, the bit index and ear hold their values, so ear may stay high.
  - FIFO writes, start (in IDLE) and stop are still honoured.
- stop, in any state: next clock goes to IDLE with ear=0, FIFO flushed, last flag cleared.
  - stop and wr in the same clock: stop wins and the byte is discarded.
  - stop and start in the same clock: stop wins.
- Counter widths must hold max(ZERO_HALF, ONE_HALF, GAP_TICKS) and LEADER_CYCLES without overflow. Counters never wrap mid-period.
- Timing exactness: each half-period is exactly H ticks. No extra tick is inserted between bits, bytes, or state changes, except STALL time.

Test Plan (ZERO_HALF=4, ONE_HALF=2, LEADER_CYCLES=3, GAP_TICKS=10, ce=1 every clock, motor=1 unless stated):
- Reset mid-stream: assert reset while ear=1 with 3 bytes queued -> ear=0, busy=0, count=0, full=0 immediately, with no clock edge required.
- Basic block: write 8'h80 with last=1, then pulse start -> 3×(4 high, 4 low) leader; then A5 as widths 2,4,2,4,4,2,4,2 cycles; then 8'h80 as one 2-cycle followed by seven 4-cycles; then 10 low ticks; busy falls exactly at IDLE entry.
- FIFO bounds (AW=2):
  - Write 5 bytes -> count=4, full=1, 5th byte dropped.
  - wr during the clock of a pop while full -> write still rejected; count drops to 3.
- Underrun: start with 1 non-last byte queued -> STALL after it, ear=0 indefinitely. Write 8'hFF with last=1 -> eight 2-high/2-low cycles, then GAP.
- Motor pause: drop motor during a high half at tick 1 of 4 for 50 clocks -> ear stays 1. Resuming gives exactly 3 more high ticks and the total waveform is otherwise unchanged.
- Abort: pulse stop together with wr during DATA -> next clock ear=0, busy=0, count=0. A subsequent start with an empty FIFO gives leader, SYNC, then STALL.

Source files
------------

// File: rtl/lynx_tape_player_if.sv
// Host-side FIFO write port of the virtual cassette deck.
//
// Handshake: the host drives wr/di/last; a byte is taken on a rising clock
// edge where wr=1 and full=0 (full as it stood before that edge). A byte
// offered while full=1 is dropped, never stalled or retried. count is the
// number of queued bytes.
//
// Signals:
//   wr    host -> deck  write strobe, one byte per clock
//   di    host -> deck  byte value
//   last  host -> deck  byte closes the current block
//   full  deck -> host  FIFO holds 2^AW bytes
//   count deck -> host  FIFO occupancy (0 .. 2^AW)
interface lynx_tape_player_if #(
  parameter int AW = 4
) ();
  logic          wr;
  logic [7:0]    di;
  logic          last;
  logic          full;
  logic [AW:0]   count;

  modport master (output wr, di, last, input full, count);
  modport slave  (input wr, di, last, output full, count);
endinterface

// File: rtl/lynx_tape_player.sv
// Virtual cassette deck producing the Lynx tape-input signal `ear`.
// Queued bytes are played as leader (0-bit cycles), sync byte, then data,
// each bit being one square cycle: H ticks high, H ticks low, MSB first.
// A tick is a clock with ce=1 and motor=1; motor low freezes playback.
//
// Ports:
//   clock      system clock
//   reset      asynchronous active-low reset
//   ce         timing tick enable
//   motor      cassette motor (low = frozen)
//   start      pulse: begin a block (honoured only when idle)
//   stop       pulse: abort playback, flush FIFO
//   fifo_if    host byte write port (wr/di/last in, full/count out)
//   busy       high whenever not idle
//   ear        tape signal
//   dbg_state  current FSM state, for observation
module lynx_tape_player #(
  parameter int          AW            = 4,
  parameter int          ZERO_HALF     = 1000,
  parameter int          ONE_HALF      = 500,
  parameter int          LEADER_CYCLES = 768,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int          GAP_TICKS     = 40000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ce,
  input  logic               motor,
  input  logic               start,
  input  logic               stop,
  lynx_tape_player_if.slave  fifo_if,
  output logic               busy,
  output logic               ear,
  output logic [2:0]         dbg_state
);

  localparam int DEPTH = 1 << AW;
  localparam int MAXH  = (ZERO_HALF > ONE_HALF) ? ZERO_HALF : ONE_HALF;
  localparam int MAXC  = (MAXH > GAP_TICKS) ? MAXH : GAP_TICKS;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int LW    = $clog2(LEADER_CYCLES + 1);

  localparam logic [CW-1:0] ZH        = CW'(ZERO_HALF);
  localparam logic [CW-1:0] OH        = CW'(ONE_HALF);
  localparam logic [CW-1:0] GW        = CW'(GAP_TICKS);
  localparam logic [LW-1:0] LEAD_LAST = LW'(LEADER_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEADER = 3'd1,
    S_SYNC   = 3'd2,
    S_DATA   = 3'd3,
    S_STALL  = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic           ear_q, ear_d;
  logic           phase_q, phase_d;     // 0 = high half, 1 = low half
  logic [CW-1:0]  cnt_q, cnt_d;         // ticks spent in current half / gap
  logic [2:0]     bit_q, bit_d;         // bit position within byte
  logic [LW-1:0]  lead_q, lead_d;       // leader cycles completed
  logic [7:0]     shreg_q, shreg_d;     // bit 7 is the bit being sent
  logic           last_q, last_d;       // byte being sent closes the block
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]    fcnt_q, fcnt_d;
  logic [8:0]     mem_q [DEPTH];

  logic           tick, full, nonempty, push, pop;
  logic [8:0]     head;
  logic [CW-1:0]  cnt_inc, half_len;

  assign tick     = ce & motor;
  assign full     = (fcnt_q == FULL_CNT);
  assign nonempty = (fcnt_q != '0);
  assign head     = mem_q[rptr_q];
  // Acceptance uses pre-edge occupancy, so a same-clock pop never frees room.
  assign push     = fifo_if.wr & ~full & ~stop;

  always_comb begin
    state_d  = state_q;
    ear_d    = ear_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    lead_d   = lead_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    pop      = 1'b0;
    cnt_inc  = cnt_q + CW'(1);
    half_len = (state_q == S_LEADER || !shreg_q[7]) ? ZH : OH;

    case (state_q)
      S_IDLE: begin
        ear_d = 1'b0;
        if (start) begin
          state_d = S_LEADER;
          phase_d = 1'b0;
          cnt_d   = '0;
          lead_d  = '0;
          bit_d   = '0;
          last_d  = 1'b0;
        end
      end
      S_LEADER, S_SYNC, S_DATA: begin
        if (tick) begin
          ear_d = ~phase_q;
          if (cnt_inc == half_len) begin
            cnt_d = '0;
            if (!phase_q) begin
              phase_d = 1'b1;
            end else begin
              // The tick emitting the last low sample also closes the bit,
              // so the next tick already starts the following bit.
              phase_d = 1'b0;
              if (state_q == S_LEADER) begin
                if (lead_q == LEAD_LAST) begin
                  lead_d  = '0;
                  state_d = S_SYNC;
                  shreg_d = SYNC_BYTE;
                  bit_d   = '0;
                end else begin
                  lead_d = lead_q + LW'(1);
                end
              end else if (bit_q != 3'd7) begin
                bit_d   = bit_q + 3'd1;
                shreg_d = {shreg_q[6:0], 1'b0};
              end else begin
                bit_d = '0;
                if (state_q == S_DATA && last_q) begin
                  state_d = S_GAP;
                end else if (nonempty) begin
                  pop     = 1'b1;
                  shreg_d = head[7:0];
                  last_d  = head[8];
                  state_d = S_DATA;
                end else begin
                  state_d = S_STALL;
                end
              end
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_STALL: begin
        ear_d = 1'b0;
        if (nonempty) begin
          pop     = 1'b1;
          shreg_d = head[7:0];
          last_d  = head[8];
          state_d = S_DATA;
          phase_d = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_GAP: begin
        ear_d = 1'b0;
        if (tick) begin
          if (cnt_inc == GW) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d = S_IDLE;
      ear_d   = 1'b0;
      phase_d = 1'b0;
      cnt_d   = '0;
      bit_d   = '0;
      lead_d  = '0;
      last_d  = 1'b0;
      pop     = 1'b0;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    if (stop) begin
      wptr_d = '0;
      rptr_d = '0;
      fcnt_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   fcnt_d = fcnt_q + (AW + 1)'(1);
        2'b01:   fcnt_d = fcnt_q - (AW + 1)'(1);
        default: fcnt_d = fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ear_q   <= 1'b0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      lead_q  <= '0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ear_q   <= ear_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      lead_q  <= lead_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Storage needs no reset: occupancy alone says which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= {fifo_if.last, fifo_if.di};
  end

  assign fifo_if.full  = full;
  assign fifo_if.count = fcnt_q;
  assign busy          = (state_q != S_IDLE);
  assign ear           = ear_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lynx_tape_player.sv
// Bench for lynx_tape_player: a sample-queue model of the tape waveform is
// checked against the DUT every clock, with literal checks on key points.
module tb_lynx_tape_player;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int ZH    = 4;
  localparam int OH    = 2;
  localparam int LC    = 3;
  localparam int GT    = 10;
  localparam logic [7:0] SYNC = 8'hA5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset, ce, motor, start, stop;
  logic busy, ear;
  logic [2:0] dbg_state;

  always #5 clock = ~clock;

  lynx_tape_player_if #(.AW(AW)) fif ();

  lynx_tape_player #(
    .AW(AW), .ZERO_HALF(ZH), .ONE_HALF(OH), .LEADER_CYCLES(LC),
    .SYNC_BYTE(SYNC), .GAP_TICKS(GT)
  ) dut (
    .clock(clock), .reset(reset), .ce(ce), .motor(motor),
    .start(start), .stop(stop), .fifo_if(fif.slave),
    .busy(busy), .ear(ear), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps the not-yet-played tape samples in a queue; each tick
  // plays one. When the queue drains during a block the next FIFO byte is
  // expanded into samples, or the deck waits for one.
  logic       m_wave [$];
  logic [8:0] m_fifo [$];
  bit         m_active, m_stall, m_final;
  logic       m_ear;

  task automatic push_half(int h, logic v);
    repeat (h) m_wave.push_back(v);
  endtask

  task automatic push_byte(logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      push_half(b[i] ? OH : ZH, 1'b1);
      push_half(b[i] ? OH : ZH, 1'b0);
    end
  endtask

  task automatic load(logic [8:0] e);
    push_byte(e[7:0]);
    if (e[8]) begin
      push_half(GT, 1'b0);
      m_final = 1'b1;
    end
  endtask

  task automatic model_clear();
    m_wave.delete();
    m_fifo.delete();
    m_active = 1'b0;
    m_stall  = 1'b0;
    m_final  = 1'b0;
    m_ear    = 1'b0;
  endtask

  always @(posedge clock or negedge reset) begin
    bit ne, fl;
    if (!reset) begin
      model_clear();
    end else begin
      ne = (m_fifo.size() != 0);
      fl = (m_fifo.size() == DEPTH);
      if (stop) begin
        model_clear();
      end else begin
        if (!m_active) begin
          if (start) begin
            m_active = 1'b1;
            m_stall  = 1'b0;
            m_final  = 1'b0;
            m_wave.delete();
            repeat (LC) begin
              push_half(ZH, 1'b1);
              push_half(ZH, 1'b0);
            end
            push_byte(SYNC);
          end
        end else if (m_stall) begin
          if (ne) begin
            load(m_fifo.pop_front());
            m_stall = 1'b0;
          end
        end else if (ce && motor) begin
          m_ear = m_wave.pop_front();
          if (m_wave.size() == 0) begin
            if (m_final)  m_active = 1'b0;
            else if (ne)  load(m_fifo.pop_front());
            else          m_stall = 1'b1;
          end
        end
        if (fif.wr && !fl) m_fifo.push_back({fif.last, fif.di});
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      check("ear",   32'(ear),       32'(m_ear));
      check("busy",  32'(busy),      32'(m_active));
      check("count", 32'(fif.count), m_fifo.size());
      check("full",  32'(fif.full),  32'(m_fifo.size() == DEPTH));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_clk();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_clks(int n);
    repeat (n) do_clk();
  endtask

  task automatic write_byte(logic [7:0] b, logic l);
    fif.wr = 1'b1; fif.di = b; fif.last = l;
    do_clk();
    fif.wr = 1'b0; fif.last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; do_clk(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; do_clk(); stop = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic exp_wave [$];
  logic got_ear  [$];
  logic got_busy [$];
  int   widths [19] = '{4, 4, 4, 2, 4, 2, 4, 4, 2, 4, 2, 2, 4, 4, 4, 4, 4, 4, 4};
  int   bad;

  initial begin
    reset = 1'b0; ce = 1'b1; motor = 1'b1; start = 1'b0; stop = 1'b0;
    fif.wr = 1'b0; fif.di = 8'h00; fif.last = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("rst_ear",   32'(ear), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_count", 32'(fif.count), 0);
    check("rst_full",  32'(fif.full), 0);
    check("rst_state", 32'(dbg_state), 0);
    reset = 1'b1;
    wait_clks(2);

    // Basic block: one 0x80 last byte; waveform from hand-listed widths.
    write_byte(8'h80, 1'b1);
    pulse_start();
    for (int k = 1; k <= 142; k++) begin
      do_clk();
      got_ear.push_back(ear);
      got_busy.push_back(busy);
    end
    foreach (widths[i]) begin
      repeat (widths[i]) exp_wave.push_back(1'b1);
      repeat (widths[i]) exp_wave.push_back(1'b0);
    end
    repeat (GT) exp_wave.push_back(1'b0);
    bad = 0;
    for (int k = 0; k < 142; k++) if (got_ear[k] !== exp_wave[k]) bad++;
    check("basic_wave_len", exp_wave.size(), 142);
    check("basic_wave_bad", bad, 0);
    check("basic_busy_gap_end", 32'(got_busy[140]), 1);
    check("basic_busy_idle",    32'(got_busy[141]), 0);
    wait_clks(3);

    // FIFO bounds: 5 writes into 4 entries; write during full pop rejected.
    for (int i = 0; i < 5; i++) write_byte(8'($urandom_range(0, 255)), 1'b0);
    check("fifo_count_full", 32'(fif.count), 4);
    check("fifo_full",       32'(fif.full), 1);
    pulse_start();
    wait_clks(71);
    fif.wr = 1'b1; fif.di = 8'($urandom_range(0, 255)); fif.last = 1'b0;
    do_clk();
    fif.wr = 1'b0;
    check("pop_full_count", 32'(fif.count), 3);
    check("pop_full_full",  32'(fif.full), 0);
    wait_clks(10);
    pulse_stop();
    check("stop_count", 32'(fif.count), 0);
    check("stop_busy",  32'(busy), 0);

    // Underrun: one non-last byte, then stall until 0xFF last arrives.
    write_byte(8'($urandom_range(0, 255)), 1'b0);
    pulse_start();
    wait_clks(156);
    check("stall_ear",  32'(ear), 0);
    check("stall_busy", 32'(busy), 1);
    write_byte(8'hFF, 1'b1);
    wait_clks(45);
    check("underrun_done", 32'(busy), 0);

    // Motor pause during the first leader high half.
    write_byte(8'($urandom_range(0, 255)), 1'b1);
    pulse_start();
    do_clk();
    check("motor_first_high", 32'(ear), 1);
    motor = 1'b0;
    for (int i = 0; i < 50; i++) begin
      do_clk();
      check("motor_hold", 32'(ear), 1);
    end
    motor = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_clk();
      check("motor_resume", 32'(ear), (i < 3) ? 1 : 0);
    end
    wait_clks(200);
    check("motor_done", 32'(busy), 0);

    // Abort with a same-clock write, then restart on an empty FIFO.
    for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)), 1'b0);
    pulse_start();
    wait_clks(80);
    stop = 1'b1; fif.wr = 1'b1; fif.di = 8'h5A;
    do_clk();
    stop = 1'b0; fif.wr = 1'b0;
    check("abort_ear",   32'(ear), 0);
    check("abort_busy",  32'(busy), 0);
    check("abort_count", 32'(fif.count), 0);
    pulse_start();
    wait_clks(77);
    check("empty_stall_busy", 32'(busy), 1);
    check("empty_stall_ear",  32'(ear), 0);
    pulse_stop();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      fif.wr   = ($urandom_range(0, 3) == 0);
      fif.di   = 8'($urandom_range(0, 255));
      fif.last = ($urandom_range(0, 7) == 0);
      start    = ($urandom_range(0, 30) == 0);
      stop     = ($urandom_range(0, 600) == 0);
      ce       = ($urandom_range(0, 3) != 0);
      motor    = ($urandom_range(0, 20) != 0);
      do_clk();
    end
    fif.wr = 1'b0; fif.last = 1'b0; start = 1'b0; stop = 1'b0;
    ce = 1'b1; motor = 1'b1;
    pulse_stop();

    // Reset mid-stream while ear is high with bytes queued.
    for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)), 1'b0);
    pulse_start();
    do_clk();
    check("pre_reset_ear", 32'(ear), 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_ear",   32'(ear), 0);
    check("async_rst_busy",  32'(busy), 0);
    check("async_rst_count", 32'(fif.count), 0);
    check("async_rst_full",  32'(fif.full), 0);
    wait_clks(2);
    reset = 1'b1;
    wait_clks(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
